// File: rtl/gps_pkg.sv
// gps_pkg: shared state encoding, gap counter width and default
// sequencing parameters for the GPS configuration sequencer.
package gps_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int GAP_W          = 16;
    localparam int DEF_NUM_MSGS   = 3;
    localparam int DEF_GAP_CYCLES = 16;

endpackage

// File: rtl/gps_cfg_sequencer.sv
// gps_cfg_sequencer: streams NUM_MSGS configuration ROM messages to a UART
// transmitter with a fixed idle gap between messages.
module gps_cfg_sequencer
    import gps_pkg::*;
#(
    parameter int NUM_MSGS   = DEF_NUM_MSGS,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] rom_message,
    output logic [5:0] rom_index,
    input  logic [7:0] rom_data,
    input  logic [5:0] rom_length,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    state_t           state, state_nx;
    logic [1:0]       msg_nx;
    logic [5:0]       idx_nx;
    logic [GAP_W-1:0] gap_cnt, gap_nx;
    logic             xfer, msg_done, last_msg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rom_message <= '0;
            rom_index   <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_nx;
            rom_message <= msg_nx;
            rom_index   <= idx_nx;
            gap_cnt     <= gap_nx;
        end
    end

    // An empty message completes in the cycle it is selected.
    always_comb begin
        xfer     = tx_valid && tx_ready;
        msg_done = (state == SEND) && ((rom_length == 6'd0) || (xfer && rom_index == rom_length - 6'd1));
        last_msg = rom_message == 2'(NUM_MSGS - 1);
        state_nx = state;
        msg_nx   = rom_message;
        idx_nx   = rom_index;
        gap_nx   = gap_cnt;
        case (state)
            IDLE: if (start) begin
                state_nx = SEND;
                msg_nx   = '0;
                idx_nx   = '0;
            end
            SEND: if (msg_done) begin
                idx_nx   = '0;
                state_nx = last_msg ? FIN : GAP;
                gap_nx   = last_msg ? gap_cnt : GAP_W'(GAP_CYCLES);
            end else if (xfer) begin
                idx_nx = rom_index + 6'd1;
            end
            GAP: begin
                gap_nx = gap_cnt - 1'b1;
                if (gap_cnt == GAP_W'(1)) begin
                    msg_nx   = rom_message + 2'd1;
                    state_nx = SEND;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state == SEND) && (rom_length != 6'd0);
        tx_data  = rom_data;
        busy     = state != IDLE;
        done     = state == FIN;
    end

endmodule

// File: doc/gps_cfg_sequencer.md
GPS_CFG_SEQUENCER -- requirements
Module: gps_cfg_sequencer

Interface
REQ-001 Parameter NUM_MSGS, default 3: number of ROM messages sent per start, selectors 0 to NUM_MSGS-1.
REQ-002 Parameter GAP_CYCLES, default 16: idle clocks inserted between consecutive messages, legal range 1 to 65535.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 start  input  1  single-cycle request to transmit the full configuration sequence.
REQ-006 rom_message  output  2  message selector driven to the configuration ROM.
REQ-007 rom_index  output  6  byte index driven to the configuration ROM.
REQ-008 rom_data  input  8  combinational ROM byte for (rom_message, rom_index).
REQ-009 rom_length  input  6  combinational ROM length of the selected message in bytes.
REQ-010 tx_data  output  8  byte offered to the UART transmitter; equals rom_data.
REQ-011 tx_valid  output  1  tx_data is a byte to send.
REQ-012 tx_ready  input  1  UART accepts tx_data this cycle.
REQ-013 busy  output  1  high from the cycle after an accepted start until the done pulse, inclusive.
REQ-014 done  output  1  one-cycle pulse marking sequence completion.

Function
REQ-015 States SHALL be IDLE, SEND, GAP and FIN, with registered encoding.
REQ-016 IDLE: when start=1, go to SEND with rom_message=0 and rom_index=0; otherwise hold.
REQ-017 Byte transfer: a byte SHALL transfer only in a cycle where tx_valid=1 and tx_ready=1.
REQ-018 SEND: tx_valid=1 whenever rom_length is non-zero.
REQ-019 Backpressure: while tx_valid=1 and tx_ready=0, rom_message, rom_index and tx_data SHALL hold stable.
REQ-020 SEND, transfer with rom_index < rom_length-1: rom_index increments by 1.
REQ-021 SEND, transfer on the last byte (rom_index = rom_length-1): rom_index returns to 0, then:
  - if rom_message = NUM_MSGS-1, go to FIN;
  - otherwise go to GAP and load the gap counter with GAP_CYCLES.
REQ-022 SEND with rom_length=0: tx_valid=0 and no byte is sent; the message is treated as complete the same cycle, following the REQ-021 rules.
REQ-023 GAP: tx_valid=0.
  - The 16-bit counter decrements each cycle.
  - At count 1, rom_message increments and the state goes to SEND.
  - Exactly GAP_CYCLES cycles are spent in GAP.
REQ-024 FIN: done=1 for exactly one cycle, busy=1 in that cycle; next state is IDLE.
REQ-025 start is ignored in SEND, GAP and FIN; a start in the same cycle as the FIN pulse is not queued.
REQ-026 Total bytes transferred per sequence SHALL equal the sum of rom_length over selectors 0 to NUM_MSGS-1; no byte is duplicated or skipped.
REQ-027 Latency: first tx_valid is asserted in the cycle after start is sampled in IDLE.

Reset
REQ-028 While rst_n=0, all of the following hold immediately and stay held, including mid-transfer:
  - state=IDLE;
  - rom_message=0, rom_index=0;
  - gap counter=0;
  - tx_valid=0, busy=0, done=0.
REQ-029 A partially sent message is abandoned on reset and not resumed; the next start restarts at message 0, byte 0.

Structure
REQ-030 State encoding, the 16-bit gap counter width and the NUM_MSGS/GAP_CYCLES defaults SHALL live in shared package gps_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; it instantiates nothing and connects to gps_rom at the parent level.

Verification
REQ-032 Nominal run: tx_ready=1, GAP_CYCLES=16, start pulse.
  - Exactly 66 transfers: 44, then 11, then 11.
  - First bytes B5 62 06 24; message-0 last byte D6; message-1 last byte 47; message-2 last byte 67.
  - 16 idle cycles between messages; done pulses once.
REQ-033 Backpressure: tx_ready random at 30% high.
  - Byte stream identical to REQ-032.
  - tx_data stable during every stall.
REQ-034 Start while busy: start pulsed during message 1 and during GAP.
  - Sequence unchanged; still 66 bytes and one done pulse.
REQ-035 Reset mid-frame: rst_n low at message 0, byte 20.
  - tx_valid and busy drop without waiting for a clock edge.
  - Next start sends B5 first, full 66 bytes.
REQ-036 Zero length: ROM model returns rom_length=0 for message 1.
  - Message 1 sends nothing; the gap is still applied.
  - 55 bytes total; done pulses once.
REQ-037 Gap boundary: GAP_CYCLES=1.
  - Exactly one tx_valid=0 cycle between messages; message 1 byte 0 equals B5.
